mem_bus_arbiter: RTL and testbench

- Shares the single main-memory port between cache 0 and cache 1.
- Grants in round-robin order, sequences each read/write through the memory handshake, and times out stalled accesses.
- Feeds completed writes to cache_coherenter as 25-bit change records {valid, data[7:0], addr[15:0]} on the matching cache_change_N port.
- Sits between the two cache controllers, the memory, and cache_coherenter.

---
 rtl/mem_bus_pkg.sv | 10 +
 rtl/rr_arbiter2.sv | 11 +
 rtl/mem_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared widths, FSM encoding and change-record packing for mem_bus_arbiter
package mem_bus_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CHANGE_W = 1 + DATA_W + ADDR_W;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    function automatic logic [CHANGE_W-1:0] pack_change(input logic [DATA_W-1:0] data, input logic [ADDR_W-1:0] addr);
        return {1'b1, data, addr};
    endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick
module rr_arbiter2 (
    input  logic req_0,
    input  logic req_1,
    input  logic last_served,
    output logic winner,
    output logic any_req
);
    assign any_req = req_0 | req_1;
    assign winner = (req_0 & req_1) ? ~last_served : req_1;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of the memory port between two caches, with timeout and write change records
module mem_bus_arbiter #(
    parameter int ADDR_W = mem_bus_pkg::ADDR_W,
    parameter int DATA_W = mem_bus_pkg::DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_0,
    input  logic                     req_1,
    input  logic                     we_0,
    input  logic                     we_1,
    input  logic [ADDR_W-1:0]        addr_0,
    input  logic [ADDR_W-1:0]        addr_1,
    input  logic [DATA_W-1:0]        wdata_0,
    input  logic [DATA_W-1:0]        wdata_1,
    output logic                     gnt_0,
    output logic                     gnt_1,
    output logic                     done_0,
    output logic                     done_1,
    output logic                     err_0,
    output logic                     err_1,
    output logic [DATA_W-1:0]        rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ready,
    output logic [DATA_W+ADDR_W:0]   cache_change_0,
    output logic [DATA_W+ADDR_W:0]   cache_change_1
);
    import mem_bus_pkg::*;
    localparam int CW = 1 + DATA_W + ADDR_W;
    state_t state, state_d;
    logic last_served, last_d, winner, winner_d, pick, any_req;
    logic [7:0] timer, timer_d;
    logic gnt_0_d, gnt_1_d, done_0_d, done_1_d, err_0_d, err_1_d, mem_req_d, mem_we_d, finish;
    logic [DATA_W-1:0] rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [CW-1:0] change_d, cc_0_d, cc_1_d;

    rr_arbiter2 u_rr (
        .req_0(req_0),
        .req_1(req_1),
        .last_served(last_served),
        .winner(pick),
        .any_req(any_req)
    );

    // mem_we/mem_addr/mem_wdata double as the latched request and hold through BUSY
    always_comb begin
        state_d = state;
        last_d = last_served;
        winner_d = winner;
        timer_d = timer;
        mem_req_d = mem_req;
        mem_we_d = mem_we;
        mem_addr_d = mem_addr;
        mem_wdata_d = mem_wdata;
        rdata_d = rdata;
        {gnt_0_d, gnt_1_d, done_0_d, done_1_d, err_0_d, err_1_d} = '0;
        cc_0_d = '0;
        cc_1_d = '0;
        finish = mem_ready || timer == 8'(TIMEOUT - 1);
        change_d = (mem_ready && mem_we) ? pack_change(mem_wdata, mem_addr) : '0;
        case (state)
            IDLE: if (any_req) begin
                state_d = BUSY;
                winner_d = pick;
                timer_d = '0;
                mem_req_d = 1'b1;
                mem_we_d = pick ? we_1 : we_0;
                mem_addr_d = pick ? addr_1 : addr_0;
                mem_wdata_d = pick ? wdata_1 : wdata_0;
                gnt_0_d = ~pick;
                gnt_1_d = pick;
            end
            BUSY: begin
                timer_d = timer + 8'd1;
                if (finish) begin
                    state_d = DONE;
                    mem_req_d = 1'b0;
                    done_0_d = ~winner;
                    done_1_d = winner;
                    err_0_d = ~winner & ~mem_ready;
                    err_1_d = winner & ~mem_ready;
                    rdata_d = (mem_ready && !mem_we) ? mem_rdata : rdata;
                    cc_0_d = winner ? '0 : change_d;
                    cc_1_d = winner ? change_d : '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d = winner;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            last_served <= 1'b1;
            winner <= 1'b0;
            timer <= '0;
            {gnt_0, gnt_1, done_0, done_1, err_0, err_1, mem_req, mem_we} <= '0;
            mem_addr <= '0;
            mem_wdata <= '0;
            rdata <= '0;
            cache_change_0 <= '0;
            cache_change_1 <= '0;
        end else begin
            state <= state_d;
            last_served <= last_d;
            winner <= winner_d;
            timer <= timer_d;
            {gnt_0, gnt_1, done_0, done_1, err_0, err_1, mem_req, mem_we} <=
                {gnt_0_d, gnt_1_d, done_0_d, done_1_d, err_0_d, err_1_d, mem_req_d, mem_we_d};
            mem_addr <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            rdata <= rdata_d;
            cache_change_0 <= cc_0_d;
            cache_change_1 <= cc_1_d;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    logic clock, reset;
    logic req_0, req_1, we_0, we_1;
    logic [15:0] addr_0, addr_1, mem_addr;
    logic [7:0] wdata_0, wdata_1, rdata, mem_wdata, mem_rdata;
    logic gnt_0, gnt_1, done_0, done_1, err_0, err_1, mem_req, mem_we, mem_ready;
    logic [24:0] cache_change_0, cache_change_1;
    int checks = 0;
    int failures = 0;

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
        .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .done_0(done_0), .done_1(done_1),
        .err_0(err_0), .err_1(err_1), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .cache_change_0(cache_change_0), .cache_change_1(cache_change_1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset;
        reset = 1'b0;
        {req_0, req_1, we_0, we_1, mem_ready} = '0;
        addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0; mem_rdata = '0;
        repeat (2) @(negedge clock);
        checks++;
        if ({gnt_0, gnt_1, done_0, done_1, err_0, err_1, mem_req, mem_we} !== 8'h00 || rdata !== 8'h00
            || mem_addr !== 16'h0 || cache_change_0 !== 25'h0 || cache_change_1 !== 25'h0) begin
            failures++;
            $display("FAIL reset_outputs: some output nonzero (mem_req=%b rdata=%h cc0=%h), required all 0", mem_req, rdata, cache_change_0);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_write;
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 16'd100; wdata_0 = 8'd123; mem_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin failures++; $display("FAIL write_gnt: gnt_0=%b gnt_1=%b, required 1 0", gnt_0, gnt_1); end
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'd100 || mem_wdata !== 8'd123) begin
            failures++; $display("FAIL write_mem: req=%b we=%b addr=%0d wdata=%0d, required 1 1 100 123", mem_req, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clock);
        checks++;
        if (done_0 !== 1'b1 || err_0 !== 1'b0 || mem_req !== 1'b0 || gnt_0 !== 1'b0) begin
            failures++; $display("FAIL write_done: done_0=%b err_0=%b mem_req=%b gnt_0=%b, required 1 0 0 0", done_0, err_0, mem_req, gnt_0);
        end
        checks++;
        if (cache_change_0 !== {1'b1, 8'd123, 16'd100} || cache_change_1 !== 25'h0) begin
            failures++; $display("FAIL write_change: cc0=%h cc1=%h, required %h 0", cache_change_0, cache_change_1, {1'b1, 8'd123, 16'd100});
        end
        req_0 = 1'b0; mem_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (cache_change_0 !== 25'h0 || done_0 !== 1'b0) begin
            failures++; $display("FAIL write_pulse: cc0=%h done_0=%b one cycle later, required 0 0", cache_change_0, done_0);
        end
    endtask

    task automatic test_both;
        int k;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        req_0 = 1'b1; req_1 = 1'b1; we_0 = 1'b0; we_1 = 1'b0; mem_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            k = 0;
            do begin
                @(negedge clock);
                k++;
            end while (!(gnt_0 || gnt_1) && k < 8);
            checks++;
            if (gnt_0 === gnt_1 || gnt_1 !== g[0]) begin
                failures++; $display("FAIL both_order%0d: gnt_0=%b gnt_1=%b, required gnt_1=%b only", g, gnt_0, gnt_1, g[0]);
            end
            if (g > 0) begin
                checks++;
                if (k !== 3) begin failures++; $display("FAIL both_turnaround%0d: %0d cycles, required 3", g, k); end
            end
        end
        req_0 = 1'b0; req_1 = 1'b0;
        @(negedge clock);
        checks++;
        if (done_1 !== 1'b1 || done_0 !== 1'b0) begin failures++; $display("FAIL both_last_done: done_0=%b done_1=%b, required 0 1", done_0, done_1); end
        mem_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_read;
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 16'h00FF;
        @(negedge clock);
        checks++;
        if (gnt_1 !== 1'b1 || mem_addr !== 16'h00FF || mem_we !== 1'b0) begin
            failures++; $display("FAIL read_gnt: gnt_1=%b addr=%h we=%b, required 1 00ff 0", gnt_1, mem_addr, mem_we);
        end
        @(negedge clock);
        checks++;
        if (mem_req !== 1'b1 || done_1 !== 1'b0 || gnt_1 !== 1'b0) begin
            failures++; $display("FAIL read_wait: mem_req=%b done_1=%b gnt_1=%b, required 1 0 0", mem_req, done_1, gnt_1);
        end
        @(negedge clock);
        mem_rdata = 8'h5A; mem_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (done_1 !== 1'b1 || err_1 !== 1'b0 || rdata !== 8'h5A) begin
            failures++; $display("FAIL read_done: done_1=%b err_1=%b rdata=%h, required 1 0 5a", done_1, err_1, rdata);
        end
        checks++;
        if (cache_change_0 !== 25'h0 || cache_change_1 !== 25'h0) begin
            failures++; $display("FAIL read_nochange: cc0=%h cc1=%h, required 0 0", cache_change_0, cache_change_1);
        end
        req_1 = 1'b0; mem_ready = 1'b0; mem_rdata = 8'h00;
        @(negedge clock);
    endtask

    task automatic test_timeout;
        int n;
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 16'h1234; wdata_0 = 8'hC3;
        @(negedge clock);
        checks++;
        if (gnt_0 !== 1'b1) begin failures++; $display("FAIL to_gnt: gnt_0=%b, required 1", gnt_0); end
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done_0 && n < 40);
        checks++;
        if (n !== 16) begin failures++; $display("FAIL to_latency: done_0 after %0d cycles, required 16", n); end
        checks++;
        if (err_0 !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL to_err: err_0=%b mem_req=%b, required 1 0", err_0, mem_req); end
        checks++;
        if (cache_change_0 !== 25'h0 || cache_change_1 !== 25'h0 || rdata !== 8'h5A) begin
            failures++; $display("FAIL to_nochange: cc0=%h cc1=%h rdata=%h, required 0 0 5a", cache_change_0, cache_change_1, rdata);
        end
        req_0 = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_ready_at_timeout;
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 16'h0042; wdata_0 = 8'h99;
        @(negedge clock);
        checks++;
        if (gnt_0 !== 1'b1) begin failures++; $display("FAIL edge_gnt: gnt_0=%b, required 1", gnt_0); end
        repeat (15) @(negedge clock);
        checks++;
        if (done_0 !== 1'b0 || mem_req !== 1'b1) begin failures++; $display("FAIL edge_pre: done_0=%b mem_req=%b, required 0 1", done_0, mem_req); end
        mem_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (done_0 !== 1'b1 || err_0 !== 1'b0) begin failures++; $display("FAIL edge_done: done_0=%b err_0=%b, required 1 0", done_0, err_0); end
        checks++;
        if (cache_change_0 !== {1'b1, 8'h99, 16'h0042} || cache_change_1 !== 25'h0) begin
            failures++; $display("FAIL edge_change: cc0=%h cc1=%h, required %h 0", cache_change_0, cache_change_1, {1'b1, 8'h99, 16'h0042});
        end
        req_0 = 1'b0; mem_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_in_busy;
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 16'h0007; wdata_0 = 8'h11;
        @(negedge clock);
        checks++;
        if (gnt_0 !== 1'b1 || mem_req !== 1'b1) begin failures++; $display("FAIL rib_gnt: gnt_0=%b mem_req=%b, required 1 1", gnt_0, mem_req); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || gnt_0 !== 1'b0) begin failures++; $display("FAIL rib_async: mem_req=%b gnt_0=%b, required 0 0", mem_req, gnt_0); end
        @(negedge clock);
        checks++;
        if (done_0 !== 1'b0 || err_0 !== 1'b0 || cache_change_0 !== 25'h0) begin
            failures++; $display("FAIL rib_nodone: done_0=%b err_0=%b cc0=%h, required 0 0 0", done_0, err_0, cache_change_0);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (gnt_0 !== 1'b1 || mem_addr !== 16'h0007) begin failures++; $display("FAIL rib_regrant: gnt_0=%b addr=%h, required 1 0007", gnt_0, mem_addr); end
        mem_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (done_0 !== 1'b1 || cache_change_0 !== {1'b1, 8'h11, 16'h0007}) begin
            failures++; $display("FAIL rib_done: done_0=%b cc0=%h, required 1 %h", done_0, cache_change_0, {1'b1, 8'h11, 16'h0007});
        end
        req_0 = 1'b0; mem_ready = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        test_reset;
        test_write;
        test_both;
        test_read;
        test_timeout;
        test_ready_at_timeout;
        test_reset_in_busy;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
